// File: rtl/fb_write_sched_if.sv
// Host-side command/stream handshake plus the frame RAM write port of fb_write_sched.
// The master drives commands and stream beats; the slave (scheduler) drives the RAM write port.
interface fb_write_sched_if #(
  parameter int COLS_LOG2 = 5,
  parameter int ADDR_W    = 2 * COLS_LOG2,
  parameter int RGB_W     = 3
);
  logic                 cmd_valid;
  logic                 cmd_ready;
  logic [1:0]           cmd_op;
  logic [COLS_LOG2-1:0] cmd_x;
  logic [COLS_LOG2-1:0] cmd_y;
  logic [RGB_W-1:0]     cmd_rgb;

  logic                 pix_valid;
  logic                 pix_ready;
  logic [RGB_W-1:0]     pix_rgb;
  logic                 pix_last;

  logic                 abort;

  logic                 we;
  logic [ADDR_W-1:0]    adr;
  logic [RGB_W-1:0]     rgb;
  logic                 busy;
  logic                 done;

  modport master (
    output cmd_valid, cmd_op, cmd_x, cmd_y, cmd_rgb,
    output pix_valid, pix_rgb, pix_last, abort,
    input  cmd_ready, pix_ready, we, adr, rgb, busy, done
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_x, cmd_y, cmd_rgb,
    input  pix_valid, pix_rgb, pix_last, abort,
    output cmd_ready, pix_ready, we, adr, rgb, busy, done
  );
endinterface

// File: rtl/fb_write_sched.sv
// Write-side sequencer for the 32x32 frame RAM: turns PIXEL / FILL / STREAM host commands
// into at most one registered RAM write per clock.
module fb_write_sched #(
  parameter int COLS_LOG2 = 5,
  parameter int ADDR_W    = 2 * COLS_LOG2,
  parameter int RGB_W     = 3
) (
  input  logic              clk,
  input  logic              reset,
  fb_write_sched_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PIXEL  = 2'd1,
    FILL   = 2'd2,
    STREAM = 2'd3
  } state_t;

  localparam logic [1:0]        OP_PIXEL  = 2'b01;
  localparam logic [1:0]        OP_FILL   = 2'b10;
  localparam logic [1:0]        OP_STREAM = 2'b11;
  localparam logic [ADDR_W-1:0] ADR_LAST  = '1;
  localparam logic [ADDR_W-1:0] ADR_ONE   = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_t               state_q, state_d;
  logic [ADDR_W-1:0]    cur_adr_q, cur_adr_d;
  logic [RGB_W-1:0]     col_q, col_d;
  logic                 we_q, we_d;
  logic [ADDR_W-1:0]    adr_q, adr_d;
  logic [RGB_W-1:0]     rgb_q, rgb_d;
  logic                 done_q, done_d;
  logic                 busy_q, busy_d;

  logic [COLS_LOG2-1:0] cmd_x_s;
  logic [COLS_LOG2-1:0] cmd_y_s;
  logic [ADDR_W-1:0]    start_adr;
  logic [ADDR_W-1:0]    next_adr;
  logic                 cmd_acc;
  logic                 pix_acc;

  assign cmd_x_s   = bus.cmd_x;
  assign cmd_y_s   = bus.cmd_y;
  assign start_adr = {cmd_y_s, cmd_x_s};
  assign next_adr  = cur_adr_q + ADR_ONE;

  // The two ready signals are the only outputs decoded combinationally from state.
  assign bus.cmd_ready = (state_q == IDLE);
  assign bus.pix_ready = (state_q == STREAM) && !bus.abort;
  assign cmd_acc       = bus.cmd_valid && bus.cmd_ready;
  assign pix_acc       = bus.pix_valid && bus.pix_ready;

  always_comb begin
    state_d   = state_q;
    cur_adr_d = cur_adr_q;
    col_d     = col_q;
    we_d      = 1'b0;
    done_d    = 1'b0;
    adr_d     = adr_q;
    rgb_d     = rgb_q;

    case (state_q)
      IDLE: begin
        if (cmd_acc) begin
          cur_adr_d = start_adr;
          col_d     = bus.cmd_rgb;
          // PIXEL and FILL register their first write on the accepting edge.
          case (bus.cmd_op)
            OP_PIXEL: begin
              state_d = PIXEL;
              we_d    = 1'b1;
              adr_d   = start_adr;
              rgb_d   = bus.cmd_rgb;
              done_d  = 1'b1;
            end
            OP_FILL: begin
              state_d = FILL;
              we_d    = 1'b1;
              adr_d   = start_adr;
              rgb_d   = bus.cmd_rgb;
              done_d  = (start_adr == ADR_LAST);
            end
            OP_STREAM: begin
              state_d = STREAM;
            end
            default: begin
              state_d = IDLE;
            end
          endcase
        end
      end

      PIXEL: begin
        state_d = IDLE;
      end

      // cur_adr_q is the address on the outputs; stop once the top address has been shown.
      FILL: begin
        if (bus.abort || (cur_adr_q == ADR_LAST)) begin
          state_d = IDLE;
        end else begin
          cur_adr_d = next_adr;
          we_d      = 1'b1;
          adr_d     = next_adr;
          rgb_d     = col_q;
          done_d    = (next_adr == ADR_LAST);
        end
      end

      // cur_adr_q is the address the next accepted beat will write; it wraps freely.
      STREAM: begin
        if (bus.abort) begin
          state_d = IDLE;
        end else if (pix_acc) begin
          cur_adr_d = next_adr;
          we_d      = 1'b1;
          adr_d     = cur_adr_q;
          rgb_d     = bus.pix_rgb;
          done_d    = bus.pix_last;
          if (bus.pix_last) begin
            state_d = IDLE;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cur_adr_q <= '0;
      col_q     <= '0;
      we_q      <= 1'b0;
      adr_q     <= '0;
      rgb_q     <= '0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cur_adr_q <= cur_adr_d;
      col_q     <= col_d;
      we_q      <= we_d;
      adr_q     <= adr_d;
      rgb_q     <= rgb_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
    end
  end

  assign bus.we   = we_q;
  assign bus.adr  = adr_q;
  assign bus.rgb  = rgb_q;
  assign bus.done = done_q;
  assign bus.busy = busy_q;

endmodule

// File: tb/tb_fb_write_sched.sv
// Directed bench for fb_write_sched: a per-cycle table of expected RAM writes and busy
// levels, filled from the command rules, checked every clock, plus literal spot checks.
`timescale 1ns/1ps
module tb_fb_write_sched;
  localparam int COLS_LOG2 = 5;
  localparam int ADDR_W    = 10;
  localparam int RGB_W     = 3;
  localparam int NADR      = 1024;

  localparam logic [1:0] OP_NOP    = 2'b00;
  localparam logic [1:0] OP_PIXEL  = 2'b01;
  localparam logic [1:0] OP_FILL   = 2'b10;
  localparam logic [1:0] OP_STREAM = 2'b11;

  logic clk = 1'b0;
  logic reset;

  fb_write_sched_if #(.COLS_LOG2(COLS_LOG2), .ADDR_W(ADDR_W), .RGB_W(RGB_W)) bus ();

  fb_write_sched #(.COLS_LOG2(COLS_LOG2), .ADDR_W(ADDR_W), .RGB_W(RGB_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [ADDR_W-1:0] adr;
    logic [RGB_W-1:0]  rgb;
    logic              done;
  } wr_t;

  wr_t exp_wr   [int];
  bit  exp_busy [int];

  int cyc      = 0;
  int n_checks = 0;
  int n_err    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_from(input int c);
    for (int k = c; k < c + NADR + 64; k++) begin
      exp_wr.delete(k);
      exp_busy.delete(k);
    end
  endtask

  // Per-cycle comparison against the expectation table.
  always @(negedge clk) begin
    wr_t e;
    bit  b;
    b = exp_busy.exists(cyc) ? exp_busy[cyc] : 1'b0;
    chk("busy", 32'(bus.busy), 32'(b));
    chk("cmd_ready", 32'(bus.cmd_ready), 32'(!b));
    if (exp_wr.exists(cyc)) begin
      e = exp_wr[cyc];
      chk("we", 32'(bus.we), 32'(1));
      chk("adr", 32'(bus.adr), 32'(e.adr));
      chk("rgb", 32'(bus.rgb), 32'(e.rgb));
      chk("done", 32'(bus.done), 32'(e.done));
    end else begin
      chk("we_idle", 32'(bus.we), 32'(0));
      chk("done_idle", 32'(bus.done), 32'(0));
    end
  end

  // Offer a command until accepted; record the writes/busy cycles it implies.
  task automatic send_cmd(input logic [1:0] op, input int x, input int y, input int rgb,
                          output int acc);
    int  waited;
    int  start;
    wr_t e;
    waited        = 0;
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_x     = 5'(x);
    bus.cmd_y     = 5'(y);
    bus.cmd_rgb   = 3'(rgb);
    while (bus.cmd_ready !== 1'b1 && waited < 2000) begin
      step();
      waited++;
    end
    chk("cmd_accept_timeout", 32'(waited < 2000), 32'(1));
    acc   = cyc;
    start = y * 32 + x;
    case (op)
      OP_PIXEL: begin
        e.adr = 10'(start); e.rgb = 3'(rgb); e.done = 1'b1;
        exp_wr[acc + 1]   = e;
        exp_busy[acc + 1] = 1'b1;
      end
      OP_FILL: begin
        for (int k = 0; k < NADR - start; k++) begin
          e.adr = 10'(start + k); e.rgb = 3'(rgb); e.done = (start + k == NADR - 1);
          exp_wr[acc + 1 + k]   = e;
          exp_busy[acc + 1 + k] = 1'b1;
        end
      end
      OP_STREAM: exp_busy[acc + 1] = 1'b1;
      default: ;
    endcase
    step();
    bus.cmd_valid = 1'b0;
  endtask

  // Stream n beats (gap[i] idle cycles before beat i); seen[i] is adr when beat i's write shows.
  task automatic stream_beats(input int start, input int n, input int rgbs[8], input int gaps[8],
                              input bit last, output int seen[8]);
    wr_t e;
    for (int i = 0; i < n; i++) begin
      for (int g = 0; g < gaps[i]; g++) begin
        exp_busy[cyc + 1] = 1'b1;
        step();
      end
      bus.pix_valid = 1'b1;
      bus.pix_rgb   = 3'(rgbs[i]);
      bus.pix_last  = last && (i == n - 1);
      chk("pix_ready_beat", 32'(bus.pix_ready), 32'(1));
      e.adr = 10'((start + i) % NADR); e.rgb = 3'(rgbs[i]); e.done = bus.pix_last;
      exp_wr[cyc + 1] = e;
      if (!e.done) exp_busy[cyc + 1] = 1'b1;
      step();
      bus.pix_valid = 1'b0;
      bus.pix_last  = 1'b0;
      seen[i] = int'(bus.adr);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    int t0;
    int seen[8];
    int rgbs[8];
    int gaps[8];

    reset         = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = OP_NOP;
    bus.cmd_x     = '0;
    bus.cmd_y     = '0;
    bus.cmd_rgb   = '0;
    bus.pix_valid = 1'b0;
    bus.pix_rgb   = '0;
    bus.pix_last  = 1'b0;
    bus.abort     = 1'b0;
    step();
    step();
    reset = 1'b0;
    step();
    chk("rst_cmd_ready", 32'(bus.cmd_ready), 32'(1));
    chk("rst_we", 32'(bus.we), 32'(0));
    chk("rst_adr", 32'(bus.adr), 32'(0));
    chk("rst_rgb", 32'(bus.rgb), 32'(0));
    chk("rst_pix_ready", 32'(bus.pix_ready), 32'(0));

    // PIXEL x=3,y=2 -> adr 67
    send_cmd(OP_PIXEL, 3, 2, 5, acc);
    chk("pix_adr", 32'(bus.adr), 32'(67));
    chk("pix_rgb", 32'(bus.rgb), 32'(5));
    chk("pix_done", 32'(bus.done), 32'(1));
    chk("pix_cmd_ready_low", 32'(bus.cmd_ready), 32'(0));
    step();
    chk("pix_cmd_ready_back", 32'(bus.cmd_ready), 32'(1));

    // NOP: nothing happens
    send_cmd(OP_NOP, 9, 9, 7, acc);
    chk("nop_busy", 32'(bus.busy), 32'(0));

    // full-frame FILL
    send_cmd(OP_FILL, 0, 0, 2, acc);
    chk("fill0_first_adr", 32'(bus.adr), 32'(0));
    repeat (1023) step();
    chk("fill0_last_adr", 32'(bus.adr), 32'(1023));
    chk("fill0_last_done", 32'(bus.done), 32'(1));
    step();

    send_cmd(OP_FILL, 31, 31, 7, acc);
    chk("fill1023_adr", 32'(bus.adr), 32'(1023));
    chk("fill1023_done", 32'(bus.done), 32'(1));
    step();
    chk("fill1023_idle", 32'(bus.busy), 32'(0));

    send_cmd(OP_FILL, 16, 31, 4, acc);
    chk("fill1008_first", 32'(bus.adr), 32'(1008));
    repeat (15) step();
    chk("fill1008_last", 32'(bus.adr), 32'(1023));
    step();

    // STREAM with wrap at the top of the frame
    rgbs = '{1, 2, 3, 4, 0, 0, 0, 0};
    gaps = '{0, 0, 3, 0, 0, 0, 0, 0};
    send_cmd(OP_STREAM, 30, 31, 0, acc);
    stream_beats(1022, 4, rgbs, gaps, 1'b1, seen);
    chk("strm_adr0", 32'(seen[0]), 32'(1022));
    chk("strm_adr1", 32'(seen[1]), 32'(1023));
    chk("strm_adr2", 32'(seen[2]), 32'(0));
    chk("strm_adr3", 32'(seen[3]), 32'(1));
    chk("strm_last_done", 32'(bus.done), 32'(1));
    chk("strm_pix_ready_after_last", 32'(bus.pix_ready), 32'(0));
    step();

    // STREAM abort: beat offered with abort is refused
    rgbs = '{6, 0, 0, 0, 0, 0, 0, 0};
    gaps = '{0, 0, 0, 0, 0, 0, 0, 0};
    send_cmd(OP_STREAM, 0, 5, 0, acc);
    stream_beats(160, 1, rgbs, gaps, 1'b0, seen);
    chk("sab_adr", 32'(seen[0]), 32'(160));
    bus.abort     = 1'b1;
    bus.pix_valid = 1'b1;
    bus.pix_rgb   = 3'd5;
    #1;
    chk("sab_pix_ready", 32'(bus.pix_ready), 32'(0));
    clear_from(cyc + 1);
    step();
    bus.abort     = 1'b0;
    bus.pix_valid = 1'b0;
    chk("sab_idle", 32'(bus.busy), 32'(0));

    // FILL abort while adr=100 is on the outputs
    send_cmd(OP_FILL, 0, 0, 3, acc);
    repeat (100) step();
    chk("fab_adr100", 32'(bus.adr), 32'(100));
    bus.abort = 1'b1;
    clear_from(cyc + 1);
    step();
    bus.abort = 1'b0;
    chk("fab_we_off", 32'(bus.we), 32'(0));
    t0 = cyc;
    send_cmd(OP_PIXEL, 7, 1, 3, acc);
    chk("fab_pixel_immediate", 32'(acc), 32'(t0));
    chk("fab_pixel_adr", 32'(bus.adr), 32'(39));
    step();

    // abort in IDLE does not block acceptance
    bus.abort = 1'b1;
    t0 = cyc;
    send_cmd(OP_PIXEL, 31, 0, 1, acc);
    bus.abort = 1'b0;
    chk("idle_abort_acc", 32'(acc), 32'(t0));
    chk("idle_abort_adr", 32'(bus.adr), 32'(31));
    step();

    // reset during a STREAM after 5 beats
    rgbs = '{1, 2, 3, 4, 5, 0, 0, 0};
    gaps = '{0, 1, 0, 0, 0, 0, 0, 0};
    send_cmd(OP_STREAM, 4, 0, 0, acc);
    stream_beats(4, 5, rgbs, gaps, 1'b0, seen);
    chk("rs_adr4", 32'(seen[4]), 32'(8));
    exp_busy[cyc + 1] = 1'b1;
    step();
    exp_busy[cyc + 1] = 1'b1;
    step();
    clear_from(cyc);
    reset = 1'b1;
    #1;
    chk("rs_we", 32'(bus.we), 32'(0));
    chk("rs_busy", 32'(bus.busy), 32'(0));
    chk("rs_adr", 32'(bus.adr), 32'(0));
    step();
    step();
    reset = 1'b0;
    step();
    chk("rs_cmd_ready", 32'(bus.cmd_ready), 32'(1));
    repeat (3) step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
